sar_code_averager: RTL and testbench

- Downstream consumer of the SAR ADC conversion result.
- Captures one 10-bit code on each rising edge of the ADC end-of-conversion flag.
- Block-averages 2^LOG2_AVG consecutive codes and queues each average in a small output FIFO.
- FIFO drains to the digital back end over a valid/ready handshake; a sticky flag reports results dropped on a full FIFO.

---
 rtl/sar_pkg.sv | 31 +++
 rtl/sar_code_averager_if.sv | 33 +++
 rtl/sar_sync_fifo.sv | 76 +++++++
 rtl/sar_code_averager.sv | 107 ++++++++++
 tb/tb_sar_code_averager.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sar_pkg                                                  |
// | Brief   : Shared constants and width helpers for the SAR code      |
// |           averager slice.                                          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package sar_pkg;

   localparam int ADC_DATA_W = 10;

   // Accumulator width: holds 2^log2_avg codes of data_w bits without overflow.
   function automatic int avg_acc_w(input int data_w, input int log2_avg);
      return data_w + log2_avg;
   endfunction

   // Ceiling log2, used for FIFO pointer and occupancy widths.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sar_code_averager_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sar_code_averager_if                                     |
// | Brief   : ADC sample input and averaged-result handshake bundle.   |
// |           master = averager side, slave = ADC/back-end side.       |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface sar_code_averager_if
   import sar_pkg::*;
#(
   parameter int DATA_W  = ADC_DATA_W,
   parameter int LEVEL_W = 3
);
   logic              eoc;
   logic [DATA_W-1:0] adc_code;
   logic              clear;
   logic [DATA_W-1:0] avg_data;
   logic              avg_valid;
   logic              avg_ready;
   logic [LEVEL_W-1:0] fifo_level;
   logic              overrun;

   modport master (
      input  eoc, adc_code, clear, avg_ready,
      output avg_data, avg_valid, fifo_level, overrun
   );

   modport slave (
      output eoc, adc_code, clear, avg_ready,
      input  avg_data, avg_valid, fifo_level, overrun
   );
endinterface
`default_nettype wire

// File: rtl/sar_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sar_sync_fifo                                            |
// | Brief   : Registered circular-buffer FIFO with synchronous flush.  |
// |           Push while full is accepted only if a pop happens too.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module sar_sync_fifo
   import sar_pkg::*;
#(
   parameter int DATA_W = ADC_DATA_W,
   parameter int DEPTH  = 4
) (
   input  wire logic                    clk,
   input  wire logic                    reset,
   input  wire logic                    clear,
   input  wire logic                    push,
   input  wire logic [DATA_W-1:0]       din,
   input  wire logic                    pop,
   output logic                         full,
   output logic                         empty,
   output logic [clog2(DEPTH):0]        level,
   output logic [DATA_W-1:0]            head
);
   localparam int c_aw = clog2(DEPTH);
   localparam logic [c_aw:0] c_full_level = (c_aw+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]   r_rd;
   logic [c_aw-1:0]   r_wr;
   logic [c_aw:0]     r_level;
   logic [DATA_W-1:0] r_last;
   logic              w_do_pop;
   logic              w_do_push;

   assign full      = (r_level == c_full_level);
   assign empty     = (r_level == '0);
   assign level     = r_level;
   // Pops from an empty FIFO are ignored; a full FIFO only takes a push alongside a pop.
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   // When empty the output keeps showing the most recently popped entry.
   assign head      = empty ? r_last : r_mem[r_rd];

   // Storage, pointers and occupancy; flush only resets pointers and level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd    <= '0;
         r_wr    <= '0;
         r_level <= '0;
         r_last  <= '0;
      end else if (clear) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr] <= din;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_do_pop) begin
            r_last <= r_mem[r_rd];
            r_rd   <= r_rd + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_level <= r_level - 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/sar_code_averager.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sar_code_averager                                        |
// | Brief   : Captures a SAR code on each rising eoc edge, averages    |
// |           2^LOG2_AVG codes and queues results for the back end.    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module sar_code_averager
   import sar_pkg::*;
#(
   parameter int DATA_W     = ADC_DATA_W,
   parameter int LOG2_AVG   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             reset,
   sar_code_averager_if.master   bus
);
   localparam int c_acc_w = avg_acc_w(DATA_W, LOG2_AVG);

   logic              r_eoc_q;
   logic              r_overrun;
   logic              w_take;
   logic              w_push;
   logic [DATA_W-1:0] w_result;
   logic              w_full;
   logic              w_empty;

   // eoc_q resets high so an eoc already asserted at reset release is not a new sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_eoc_q <= 1'b1;
      end else begin
         r_eoc_q <= bus.eoc;
      end
   end

   assign w_take = bus.eoc & ~r_eoc_q;

   generate
      if (LOG2_AVG == 0) begin : g_pass
         assign w_push   = w_take;
         assign w_result = bus.adc_code;
      end else begin : g_avg
         logic [c_acc_w-1:0]  r_acc;
         logic [LOG2_AVG-1:0] r_cnt;
         logic [c_acc_w-1:0]  w_sum;
         logic                w_last;

         assign w_sum    = r_acc + {{LOG2_AVG{1'b0}}, bus.adc_code};
         assign w_last   = &r_cnt;
         assign w_push   = w_take & w_last;
         // Truncating divide by the block length.
         assign w_result = DATA_W'(w_sum >> LOG2_AVG);

         // Block accumulator: a completed block restarts from zero.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else if (bus.clear) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else if (w_take) begin
               if (w_last) begin
                  r_acc <= '0;
                  r_cnt <= '0;
               end else begin
                  r_acc <= w_sum;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   endgenerate

   // Sticky drop flag: a result arrived with the FIFO full and nothing leaving.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overrun <= 1'b0;
      end else if (bus.clear) begin
         r_overrun <= 1'b0;
      end else if (w_push && w_full && !bus.avg_ready) begin
         r_overrun <= 1'b1;
      end
   end

   sar_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear),
      .push  (w_push),
      .din   (w_result),
      .pop   (bus.avg_ready),
      .full  (w_full),
      .empty (w_empty),
      .level (bus.fifo_level),
      .head  (bus.avg_data)
   );

   assign bus.avg_valid = ~w_empty;
   assign bus.overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_sar_code_averager.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_sar_code_averager                                     |
// | Brief   : Directed bench for an averaging instance (4 codes) and a |
// |           pass-through instance sharing the same stimulus.         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_sar_code_averager;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       eoc = 1'b0;
   logic [9:0] adc_code = '0;
   logic       clear = 1'b0;
   logic       avg_ready = 1'b1;

   int n_checks = 0;
   int n_err    = 0;

   sar_code_averager_if #(.DATA_W(10), .LEVEL_W(3)) bus ();
   sar_code_averager_if #(.DATA_W(10), .LEVEL_W(3)) bus_pt ();

   assign bus.eoc          = eoc;
   assign bus.adc_code     = adc_code;
   assign bus.clear        = clear;
   assign bus.avg_ready    = avg_ready;
   assign bus_pt.eoc       = eoc;
   assign bus_pt.adc_code  = adc_code;
   assign bus_pt.clear     = clear;
   assign bus_pt.avg_ready = avg_ready;

   sar_code_averager #(.DATA_W(10), .LOG2_AVG(2), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   sar_code_averager #(.DATA_W(10), .LOG2_AVG(0), .FIFO_DEPTH(DEPTH)) dut_pt (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_pt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: list of codes in the current block, result queues per instance.
   int  m_block[$];
   int  q_a[$];
   int  q_p[$];
   bit  ov_a = 1'b0;
   bit  ov_p = 1'b0;
   bit  m_prev = 1'b1;
   bit  m_take;
   bit  m_have;
   int  m_res;
   int  m_sum;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_block.delete();
         q_a.delete();
         q_p.delete();
         ov_a   = 1'b0;
         ov_p   = 1'b0;
         m_prev = 1'b1;
      end else begin
         m_take = eoc && !m_prev;
         m_prev = eoc;
         if (clear) begin
            m_block.delete();
            q_a.delete();
            q_p.delete();
            ov_a = 1'b0;
            ov_p = 1'b0;
         end else begin
            m_have = 1'b0;
            if (m_take) begin
               m_block.push_back(int'(adc_code));
               if (m_block.size() == 4) begin
                  m_sum = 0;
                  foreach (m_block[i]) m_sum += m_block[i];
                  m_res  = m_sum / 4;
                  m_have = 1'b1;
                  m_block.delete();
               end
            end
            if (avg_ready && q_a.size() > 0) void'(q_a.pop_front());
            if (avg_ready && q_p.size() > 0) void'(q_p.pop_front());
            if (m_have) begin
               if (q_a.size() < DEPTH) q_a.push_back(m_res);
               else ov_a = 1'b1;
            end
            if (m_take) begin
               if (q_p.size() < DEPTH) q_p.push_back(int'(adc_code));
               else ov_p = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("avg_valid", int'(bus.avg_valid), int'(q_a.size() != 0));
      chk("avg_level", int'(bus.fifo_level), q_a.size());
      chk("avg_overrun", int'(bus.overrun), int'(ov_a));
      if (q_a.size() != 0) chk("avg_data", int'(bus.avg_data), q_a[0]);
      chk("pt_valid", int'(bus_pt.avg_valid), int'(q_p.size() != 0));
      chk("pt_level", int'(bus_pt.fifo_level), q_p.size());
      chk("pt_overrun", int'(bus_pt.overrun), int'(ov_p));
      if (q_p.size() != 0) chk("pt_data", int'(bus_pt.avg_data), q_p[0]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int code);
      eoc      = 1'b1;
      adc_code = 10'(code);
      tick();
      eoc = 1'b0;
      tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_valid", int'(bus.avg_valid), 0);
      chk("rst_data", int'(bus.avg_data), 0);
      chk("rst_level", int'(bus.fifo_level), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      reset = 1'b1;
      tick();

      // Average of four codes plus pass-through visibility.
      sample(138);
      sample(388);
      sample(367);
      eoc = 1'b1; adc_code = 10'd102;
      tick();
      chk("t1_valid", int'(bus.avg_valid), 1);
      chk("t1_avg", int'(bus.avg_data), 248);
      chk("t1_pt", int'(bus_pt.avg_data), 102);
      eoc = 1'b0;
      tick();
      chk("t1_level", int'(bus.fifo_level), 0);

      eoc = 1'b1; adc_code = 10'h08A;
      tick();
      chk("pt_first", int'(bus_pt.avg_data), 'h08A);
      chk("pt_first_v", int'(bus_pt.avg_valid), 1);
      adc_code = 10'h184;
      eoc = 1'b0;
      tick();
      eoc = 1'b1;
      tick();
      chk("pt_second", int'(bus_pt.avg_data), 'h184);
      eoc = 1'b0;
      tick();
      do_clear();

      // eoc held high counts once.
      eoc = 1'b1; adc_code = 10'd1023;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("hold_nopush", int'(bus.avg_valid), 0);
      end
      eoc = 1'b0;
      tick();
      sample(1023);
      sample(1023);
      eoc = 1'b1;
      tick();
      chk("hold_avg", int'(bus.avg_data), 1023);
      chk("hold_avg_v", int'(bus.avg_valid), 1);
      eoc = 1'b0;
      tick();

      // Fill the FIFO and overrun it.
      avg_ready = 1'b0;
      for (int c = 1; c <= 20; c++) sample(c);
      chk("full_level", int'(bus.fifo_level), 4);
      chk("full_ovr", int'(bus.overrun), 1);
      avg_ready = 1'b1;
      chk("drain0", int'(bus.avg_data), 2);
      tick();
      chk("drain1", int'(bus.avg_data), 6);
      tick();
      chk("drain2", int'(bus.avg_data), 10);
      tick();
      chk("drain3", int'(bus.avg_data), 14);
      tick();
      chk("drained", int'(bus.avg_valid), 0);
      do_clear();
      chk("clr_ovr", int'(bus.overrun), 0);

      // Push and pop in the same cycle while full.
      avg_ready = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         for (int k = 0; k < 4; k++) sample(b * 100);
      end
      for (int k = 0; k < 3; k++) sample(500);
      avg_ready = 1'b1;
      eoc = 1'b1; adc_code = 10'd500;
      tick();
      avg_ready = 1'b0;
      eoc = 1'b0;
      chk("pp_level", int'(bus.fifo_level), 4);
      chk("pp_ovr", int'(bus.overrun), 0);
      chk("pp_head", int'(bus.avg_data), 200);
      tick();
      avg_ready = 1'b1;
      repeat (5) tick();
      do_clear();

      // clear mid-block, colliding with a sample.
      sample(10'h3FF);
      sample(10'h3FF);
      eoc = 1'b1; adc_code = 10'h3FF; clear = 1'b1;
      tick();
      eoc = 1'b0; clear = 1'b0;
      tick();
      chk("clr_level", int'(bus.fifo_level), 0);
      for (int k = 0; k < 3; k++) sample(10'h100);
      eoc = 1'b1;
      tick();
      chk("clr_avg", int'(bus.avg_data), 256);
      eoc = 1'b0;
      tick();

      // Asynchronous reset mid-block with eoc high across release.
      sample(10'h3FF);
      sample(10'h3FF);
      #2;
      reset = 1'b0;
      eoc = 1'b1; adc_code = 10'h3FF;
      #1;
      chk("arst_level", int'(bus.fifo_level), 0);
      chk("arst_ovr", int'(bus.overrun), 0);
      tick();
      reset = 1'b1;
      tick();
      tick();
      eoc = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) sample(10'h100);
      eoc = 1'b1;
      tick();
      chk("rst_avg", int'(bus.avg_data), 256);
      chk("rst_avg_v", int'(bus.avg_valid), 1);
      eoc = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
`default_nettype wire
